// File: rtl/logic_ops_pkg.sv
// Shared op-code constants and FSM encodings for the bit-serial logic datapath.
package logic_ops_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Truth-table encoded: result bit = op[{x,y}]
    localparam logic [3:0] OP_AND    = 4'b1000;
    localparam logic [3:0] OP_OR     = 4'b1110;
    localparam logic [3:0] OP_XOR    = 4'b0110;
    localparam logic [3:0] OP_NAND   = 4'b0111;
    localparam logic [3:0] OP_NOR    = 4'b0001;
    localparam logic [3:0] OP_PASS_A = 4'b1100;

endpackage

// File: rtl/logic_bit_cell.sv
// Combinational 1-bit logic cell: output is the truth-table entry selected by {x,y}.
module logic_bit_cell (
    input  logic       x,
    input  logic       y,
    input  logic [3:0] s,
    output logic       f
);

    logic [1:0] w_sel;

    assign w_sel = {x, y};
    assign f     = s[w_sel];

endmodule

// File: rtl/bit_serial_logic_seq.sv
// Bit-serial word sequencer driving one logic_bit_cell, LSB first.
// Optional zero-result flag enabled by defining LOGIC_SEQ_ZERO_FLAG_EN.
module bit_serial_logic_seq
    import logic_ops_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             w_x;
    logic             w_y;
    logic             w_f;
    logic             w_last;
    logic             w_accept;

    assign w_x      = r_a[r_idx];
    assign w_y      = r_b[r_idx];
    assign w_last   = (r_idx == CNT_W'(WIDTH - 1));
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    logic_bit_cell u_cell (
        .x (w_x),
        .y (w_y),
        .s (r_op),
        .f (w_f)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE,
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_op     <= op;
                r_idx    <= '0;
                r_result <= '0;
            end else if (r_state == S_RUN) begin
                // Shifting in from the MSB lands bit idx at result[idx] after WIDTH shifts
                r_result <= {w_f, r_result[WIDTH-1:1]};
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic r_any;
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_any <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_any <= r_any | w_f;
            if (w_last) begin
                r_zero <= ~(r_any | w_f);
            end
        end
    end

    assign zero = r_zero;
`endif

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_bit_serial_logic_seq.sv
// Directed self-checking bench for bit_serial_logic_seq (WIDTH=8).
module tb_bit_serial_logic_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic       zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit_serial_logic_seq #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        .zero   (zero),
`endif
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch it for 14 cycles after the accepting edge.
    // inject_k >= 0 re-asserts start with a=8'hFF at that cycle (should be ignored).
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [3:0] top, input logic [7:0] exp, input int inject_k);
        int         busy_cnt;
        int         done_cnt;
        int         done_k;
        logic [7:0] res;
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = -1;
        res      = 8'h00;
        a = ta; b = tb; op = top; start = 1'b1;
        step();
        start = 1'b0;
        a = 8'h00; b = 8'h00; op = 4'h0;
        for (int k = 0; k < 14; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                res = result;
            end
            if (k == inject_k) begin
                start = 1'b1;
                a     = 8'hFF;
            end else if (k == inject_k + 1) begin
                start = 1'b0;
            end
            step();
        end
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_latency"}, done_k, 8);
        check({tag, "_result_at_done"}, res, exp);
        check({tag, "_result_held"}, result, exp);
    endtask

    initial begin
        int dk;
        bit found;

        rst_n = 1'b0; start = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00;
        step();
        step();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 8'h00);
        rst_n = 1'b1;

        // Idle with no start
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check("idle_result", result, 8'h00);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            check("idle_zero", zero, 1'b0);
`endif
        end

        run_op("and",  8'hF0, 8'hAA, 4'b1000, 8'hA0, -1);
        run_op("or",   8'hF0, 8'hAA, 4'b1110, 8'hFA, -1);
        run_op("xor",  8'hF0, 8'hAA, 4'b0110, 8'h5A, -1);
        run_op("nand", 8'hF0, 8'hAA, 4'b0111, 8'h5F, -1);
        run_op("nor",  8'hF0, 8'hAA, 4'b0001, 8'h05, -1);
        run_op("pass", 8'h3C, 8'hAA, 4'b1100, 8'h3C, -1);

        run_op("ignore_start", 8'h0F, 8'hFF, 4'b1000, 8'h0F, 2);

        // Back-to-back: second start issued in the DONE cycle
        a = 8'hF0; b = 8'hAA; op = 4'b1000; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("b2b_first_done_seen", found, 1'b1);
        check("b2b_first_result", result, 8'hA0);
        a = 8'h33; b = 8'h55; op = 4'b0110; start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_no_bubble_busy", busy, 1'b1);
        check("b2b_no_bubble_done", done, 1'b0);
        check("b2b_result_cleared", result, 8'h00);
        dk = -1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                dk = k;
                break;
            end
            step();
        end
        check("b2b_second_latency", dk, 8);
        check("b2b_second_result", result, 8'h66);
        step();

        // Reset mid-run while idx=4 is being processed
        a = 8'hF0; b = 8'hAA; op = 4'b1110; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("midrun_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_done", done, 1'b0);
        check("midrun_rst_result", result, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle_busy", busy, 1'b0);
        run_op("post_rst_or", 8'hF0, 8'hAA, 4'b1110, 8'hFA, -1);

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        run_op("zero_and", 8'hF0, 8'h0F, 4'b1000, 8'h00, -1);
        check("zero_flag_set", zero, 1'b1);
        run_op("zero_or", 8'hF0, 8'h0F, 4'b1110, 8'hFF, -1);
        check("zero_flag_clear", zero, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bit_serial_logic_seq.md
Name: bit_serial_logic_seq

Overview:
- Word-level sequencer that drives a shared 1-bit logic cell across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Sits between a requester (start/done handshake) and the bit-level logic datapath.
- Latches the operands and the 4-bit function select, iterates a bit counter, and assembles the result word in a shift register.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op  input  4  function select, truth-table encoded: bit = op[{x,y}].
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  assembled result; held stable until the next accepted start.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any state, including mid-RUN):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal operand and op registers and the bit counter are cleared.
  - No partial result survives.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b and op, clears idx and the result shift register, then goes to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each cycle, bit idx of a/b feeds the cell (x=a[idx], y=b[idx]). Cell output f = op_q[{x,y}] shifts into the result register so that result[idx]=f. idx increments. On the cycle that processes idx=WIDTH-1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle; result is final. start=1 here is accepted exactly as in IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: start sampled at edge N gives busy high for edges N+1..N+WIDTH, and done high for the cycle after edge N+WIDTH. Total WIDTH+1 cycles from start to done.
- start during RUN is ignored; no queueing, and latched operands are unaffected.
- a, b and op may change freely after the accepting edge.
- result register:
  - During RUN, it holds the partial word; requesters must not use it until done.
  - After DONE, it holds its value through IDLE until the next accepted start clears it.
- The counter never wraps within an operation; idx is reset to 0 on every accept.
- Example op codes: AND=4'b1000, OR=4'b1110, XOR=4'b0110, NAND=4'b0111, NOR=4'b0001, pass A=4'b1100.

Optional Feature:
- Macro LOGIC_SEQ_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit).
  - Reset value 0.
  - Updated at the DONE transition to (final result == 0); held until the next DONE; cleared on reset.
  - Computed incrementally: a running OR of shifted-in bits. No WIDTH-wide compare.
- Undefined: no zero port, no extra flops; all other behaviour identical.

Decomposition:
- Shared package/include logic_ops_pkg:
  - op code constants (OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_PASS_A).
  - FSM state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2).
- Sub-module logic_bit_cell: purely combinational 1-bit cell with inputs x, y, s[3:0] and output f = s[{x,y}]. Instantiated once by the sequencer so it is reusable by other datapaths.

Test Plan:
- Reset then idle, WIDTH=8: rst_n low 2 cycles then high, no start -> busy=0, done=0, result=8'h00 for 20 cycles.
- Basic ops, a=8'hF0, b=8'hAA:
  - op=AND -> result 8'hA0.
  - op=OR -> 8'hFA.
  - op=XOR -> 8'h5A.
  - op=NAND -> 8'h5F.
  - In every case done pulses exactly once, 9 cycles after start, and busy is high for exactly 8 cycles.
- Start ignored while busy: start a=8'h0F, b=8'hFF, op=AND; re-assert start with a=8'hFF at cycle 3 -> result 8'h0F, single done.
- Back-to-back: assert start in the DONE cycle with a=8'h33, b=8'h55, op=XOR -> first result delivered, then busy rises next cycle with no IDLE bubble; second result 8'h66.
- Reset mid-operation: drop rst_n during RUN at idx=4 -> busy, done and result go to 0 immediately. A new start after release yields the correct full result.
- LOGIC_SEQ_ZERO_FLAG_EN defined:
  - a=8'hF0, b=8'h0F, op=AND -> result 8'h00, zero=1 at done.
  - Then op=OR -> result 8'hFF, zero=0.
